// File: rtl/mult_div_unit_if.sv
// Request/result bundle between pipeline control and the iterative multiply/divide unit.
// The control side drives the request; the unit drives busy/done and the HI/LO registers.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             div_zero_o;

    modport master (
        output start_i, op_i, a_i, b_i,
        input  busy_o, done_o, hi_o, lo_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i,
        output busy_o, done_o, hi_o, lo_o, div_zero_o
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, plus MTHI/MTLO.
// Sign-magnitude core: unsigned shift-add / restoring divide, signs applied in FIX.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    mult_div_unit_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    // Reset asserts asynchronously but is released only on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;

    // Operand conditioning at accept time
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign signed_op = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
    assign a_neg     = signed_op & bus.a_i[WIDTH-1];
    assign b_neg     = signed_op & bus.b_i[WIDTH-1];
    assign a_mag     = a_neg ? -bus.a_i : bus.a_i;
    assign b_mag     = b_neg ? -bus.b_i : bus.b_i;

    // Multiply step: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_step;

    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {add_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
    // The difference is taken mod 2^WIDTH; it is only kept when it is < divisor.
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_step;

    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, opnd_q};
    assign rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
    assign rem_new  = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
    assign div_step = {rem_new, acc_q[WIDTH-2:0], rem_ge};

    logic [2*WIDTH-1:0] prod_fix;
    assign prod_fix = neg_lo_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    case (bus.op_i)
                        OP_MULT, OP_MULTU: begin
                            acc_d    = {{WIDTH{1'b0}}, b_mag};
                            opnd_d   = a_mag;
                            is_div_d = 1'b0;
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = a_neg ^ b_neg;
                            dz_d     = 1'b0;
                            cnt_d    = CNT_W'(WIDTH);
                            state_d  = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div_d = 1'b1;
                            cnt_d    = CNT_W'(WIDTH);
                            state_d  = RUN;
                            if (bus.b_i == '0) begin
                                // Divide by zero falls out of the datapath as q=all ones, r=dividend
                                acc_d    = {{WIDTH{1'b0}}, bus.a_i};
                                opnd_d   = '0;
                                neg_lo_d = 1'b0;
                                neg_hi_d = 1'b0;
                                dz_d     = 1'b1;
                            end else begin
                                acc_d    = {{WIDTH{1'b0}}, a_mag};
                                opnd_d   = b_mag;
                                neg_lo_d = a_neg ^ b_neg;
                                neg_hi_d = a_neg;
                                dz_d     = 1'b0;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = bus.a_i;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.a_i;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy_o     = (state_q == RUN);
    assign bus.done_o     = done_q;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
    assign bus.div_zero_o = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference: architectural MIPS results computed with ordinary integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        longint      sa, sb, sp;
        logic [63:0] up;
        int          ia, ib;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            3'd0: begin
                sa = $signed(a);
                sb = $signed(b);
                sp = sa * sb;
                {hi, lo} = sp;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {hi, lo} = up;
            end
            default: begin
                dz = (b == 0);
                if (b == 0) begin
                    lo = '1;
                    hi = a;
                end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = '0;
                end else if (op == 3'd2) begin
                    ia = $signed(a);
                    ib = $signed(b);
                    lo = ia / ib;
                    hi = ia % ib;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Drives one request and measures edges-to-done and busy cycles; returns at #1 after
    // the done edge, so an immediately following call starts in the done cycle.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i = op;
        bus.a_i = a;
        bus.b_i = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.a_i = $urandom;
        bus.b_i = $urandom;
        if (bus.busy_o) busy_n++;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done_o) break;
            if (bus.busy_o) busy_n++;
            if (poke && (lat == 5 || lat == 6)) begin
                bus.start_i = 1'b1;
                bus.op_i = 3'd1;
            end else begin
                bus.start_i = 1'b0;
            end
        end
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy_o, bus.done_o, bus.div_zero_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {bus.busy_o, bus.done_o, bus.div_zero_o});
        end
        checks++;
        if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo got %h/%h want 0/0", bus.hi_o, bus.lo_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_multu_max();
        int lat, bn;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bn);
        checks++;
        if (lat != 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
        checks++;
        if (bn != 32) begin errors++; $display("FAIL multu_busy got %0d want 32", bn); end
        checks++;
        if (bus.hi_o !== 32'hFFFF_FFFE || bus.lo_o !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max got %h_%h want fffffffe_00000001", bus.hi_o, bus.lo_o);
        end
    endtask

    task automatic test_div_zero();
        int lat, bn;
        issue(3'd3, 32'd100, 32'd0, 1'b0, lat, bn);
        checks++;
        if (bus.lo_o !== 32'hFFFF_FFFF || bus.hi_o !== 32'd100 || bus.div_zero_o !== 1'b1) begin
            errors++;
            $display("FAIL divu_zero got hi=%h lo=%h dz=%b want 64/ffffffff/1", bus.hi_o, bus.lo_o, bus.div_zero_o);
        end
        issue(3'd1, 32'd3, 32'd4, 1'b0, lat, bn);
        checks++;
        if (bus.lo_o !== 32'd12 || bus.hi_o !== 32'd0 || bus.div_zero_o !== 1'b0) begin
            errors++;
            $display("FAIL dz_clear got hi=%h lo=%h dz=%b want 0/c/0", bus.hi_o, bus.lo_o, bus.div_zero_o);
        end
    endtask

    task automatic test_signed();
        int lat, bn;
        issue(3'd0, 32'hFFFF_FFF9, 32'd6, 1'b0, lat, bn);
        checks++;
        if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFD6) begin
            errors++;
            $display("FAIL mult_neg got %h_%h want ffffffff_ffffffd6", bus.hi_o, bus.lo_o);
        end
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bn);
        checks++;
        if (bus.lo_o !== 32'hFFFF_FFFD || bus.hi_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_neg got hi=%h lo=%h want ffffffff/fffffffd", bus.hi_o, bus.lo_o);
        end
    endtask

    task automatic test_overflow_ignore();
        int lat, bn;
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bn);
        checks++;
        if (lat != 33) begin errors++; $display("FAIL ovf_latency got %0d want 33", lat); end
        checks++;
        if (bus.lo_o !== 32'h8000_0000 || bus.hi_o !== 32'h0 || bus.div_zero_o !== 1'b0) begin
            errors++;
            $display("FAIL div_ovf got hi=%h lo=%h dz=%b want 0/80000000/0", bus.hi_o, bus.lo_o, bus.div_zero_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_queued got busy=%b done=%b want 0/0", bus.busy_o, bus.done_o);
        end
    endtask

    task automatic test_mt();
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i = 3'd4;
        bus.a_i = 32'h1234_5678;
        @(posedge clk);
        #1;
        checks++;
        if (bus.hi_o !== 32'h1234_5678 || bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mthi got hi=%h done=%b busy=%b want 12345678/1/0", bus.hi_o, bus.done_o, bus.busy_o);
        end
        bus.op_i = 3'd5;
        bus.a_i = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        checks++;
        if (bus.lo_o !== 32'h9ABC_DEF0 || bus.hi_o !== 32'h1234_5678 || bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h done=%b busy=%b", bus.hi_o, bus.lo_o, bus.done_o, bus.busy_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done_o !== 1'b0) begin errors++; $display("FAIL mt_done_pulse got %b want 0", bus.done_o); end
    endtask

    task automatic test_reserved();
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i = 3'd6;
        bus.a_i = $urandom;
        bus.b_i = $urandom;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reserved_flags got busy=%b done=%b want 0/0", bus.busy_o, bus.done_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.hi_o !== 32'h1234_5678 || bus.lo_o !== 32'h9ABC_DEF0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reserved_hilo got %h/%h done=%b", bus.hi_o, bus.lo_o, bus.done_o);
        end
    endtask

    task automatic test_reset_mid();
        bit done_seen = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i = 3'd3;
        bus.a_i = 32'd1000;
        bus.b_i = 32'd7;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_async got busy=%b hi=%h lo=%h want 0/0/0", bus.busy_o, bus.hi_o, bus.lo_o);
        end
        repeat (3) begin @(posedge clk); #1; if (bus.done_o) done_seen = 1'b1; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (bus.done_o) done_seen = 1'b1; end
        checks++;
        if (done_seen || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got done_seen=%b busy=%b want 0/0", done_seen, bus.busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        issue(3'd3, 32'd1000, 32'd7, 1'b0, lat, bn);
        checks++;
        if (lat != 33 || bus.lo_o !== 32'd142 || bus.hi_o !== 32'd6) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d hi=%h lo=%h want 33/6/8e", lat, bus.hi_o, bus.lo_o);
        end
        issue(3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, lat, bn);
        checks++;
        if (lat != 33 || bus.lo_o !== 32'd6 || bus.hi_o !== 32'd0) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d hi=%h lo=%h want 33/0/6", lat, bus.hi_o, bus.lo_o);
        end
    endtask

    task automatic test_random();
        int lat, bn;
        logic [2:0] op;
        logic [W-1:0] a, b, ehi, elo;
        logic edz;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = a >> $urandom_range(0, 31); b = b >> $urandom_range(0, 31); end
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(op, a, b, ehi, elo, edz);
            issue(op, a, b, 1'b0, lat, bn);
            checks++;
            if (lat != 33 || bus.hi_o !== ehi || bus.lo_o !== elo || bus.div_zero_o !== edz) begin
                errors++;
                $display("FAIL random op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h dz=%b want 33 hi=%h lo=%h dz=%b",
                         op, a, b, lat, bus.hi_o, bus.lo_o, bus.div_zero_o, ehi, elo, edz);
            end
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.op_i = '0;
        bus.a_i = '0;
        bus.b_i = '0;
        test_reset();
        test_multu_max();
        test_div_zero();
        test_signed();
        test_overflow_ignore();
        test_mt();
        test_reserved();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit; successor to the single-cycle combinational ALU in the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in internal HI/LO registers.
- Also executes MTHI and MTLO.
- Sits beside the ALU. Control stalls the pipeline/PC on busy_o; MFHI/MFLO read hi_o/lo_o directly.

Parameters:
- WIDTH, 32, operand/HI/LO width; even, >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk_i, input, 1: single clock, rising edge.
- rst_n_i, input, 1: asynchronous active-low reset; assert async, release sync to clk_i.
- start_i, input, 1: request; sampled only when busy_o=0.
- op_i, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
- a_i, input, WIDTH: rs operand (multiplicand/dividend/MTxx source).
- b_i, input, WIDTH: rt operand (multiplier/divisor).
- busy_o, output, 1: operation in progress.
- done_o, output, 1: one-cycle pulse; hi_o/lo_o hold the new result.
- hi_o, output, WIDTH: HI register (product high half / remainder).
- lo_o, output, WIDTH: LO register (product low half / quotient).
- div_zero_o, output, 1: last DIV/DIVU had b_i==0.

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE; busy_o=0, done_o=0, hi_o=0, lo_o=0, div_zero_o=0; counter and working registers cleared.
- States: IDLE, RUN, FIX.
- IDLE:
  - start_i=1 with op MULT/MULTU/DIV/DIVU: latch operands. For signed ops, latch magnitudes |a|,|b| and the result signs. Counter=WIDTH, busy_o=1, state RUN. div_zero_o updates to (op is DIV/DIVU && b_i==0); MULT/MULTU clear it.
  - start_i=1 with MTHI/MTLO: write a_i to hi/lo at that edge, done_o=1 next cycle, stay IDLE, busy_o stays 0.
  - Reserved op or start_i=0: no effect.
- RUN: one iteration per cycle, exactly WIDTH cycles; counter decrements; at counter==1 go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator, unsigned magnitudes.
  - Divide: restoring, one quotient bit per cycle, unsigned magnitudes.
- FIX: apply signs and write hi/lo; done_o=1 for that one cycle; busy_o=0; return to IDLE.
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: quotient negated if signs differ (truncate toward zero); remainder takes the dividend's sign.
- Latency: start edge at t -> hi/lo written and done_o high after edge t+WIDTH+1; busy_o high from t+1 through t+WIDTH.
- A new start_i may be accepted in the same cycle done_o is high (state is IDLE).
- start_i while busy_o=1: ignored, no queuing; operands may change freely.
- Divide by zero: lo = all ones, hi = a_i (unsigned dividend as given). div_zero_o=1 until the next accepted MULT/DIV.
- Signed overflow (-2^(W-1) / -1): lo = -2^(W-1), hi = 0; no flag.
- Reset mid-operation: aborts immediately; no done_o pulse; hi/lo return to 0.
- hi_o/lo_o change only at FIX, on MTHI/MTLO, or at reset; during RUN they hold previous values.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done_o exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy_o high for 32 cycles.
- MULT a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6; then DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_zero_o=1; following MULTU 3*4 -> lo=12, hi=0, div_zero_o=0.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then start_i pulsed mid-RUN with different operands -> ignored, result unchanged.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi_o/lo_o update one edge later, done_o pulses each, busy_o never asserts.
- rst_n_i driven low 10 cycles into a DIVU -> busy_o/hi_o/lo_o go 0 without waiting for a clock edge, no done_o. Back-to-back start in the done_o cycle is accepted, with the second result 33 cycles later.
